// File: rtl/vrf_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vrf_addr_sequencer
// Description : Walks the LMUL register group of one vector instruction word by
//               word, issuing vs1/vs2 read addresses and the delayed vd write.
// Revision    : 1.0 - initial release
// ============================================================================
module vrf_addr_sequencer #(
  parameter int VLEN       = 4096,
  parameter int VLANE_NUM  = 8,
  parameter int W_PIPE_LAT = 4,
  parameter int MEM_DEPTH  = VLEN / VLANE_NUM,
  parameter int AW         = $clog2(MEM_DEPTH),
  parameter int REG_WORDS  = VLEN / 32 / VLANE_NUM,
  parameter int CW         = $clog2(8 * REG_WORDS) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  output logic            ready_o,
  input  logic [1:0]      lmul_i,
  input  logic [CW-1:0]   words_i,
  input  logic [8*AW-1:0] raddr0_base_i,
  input  logic [8*AW-1:0] raddr1_base_i,
  input  logic [8*AW-1:0] waddr_base_i,
  output logic            ren_o,
  output logic [AW-1:0]   raddr0_o,
  output logic [AW-1:0]   raddr1_o,
  output logic            wen_o,
  output logic [AW-1:0]   waddr_o,
  output logic            done_o
);

  localparam int WOFF_W = $clog2(REG_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [8*AW-1:0]     r_base0, r_base1, r_basew;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_ridx;
  logic [WOFF_W-1:0]   r_woff;
  logic                r_ren;
  logic [AW-1:0]       r_raddr0, r_raddr1, r_wa;
  logic [W_PIPE_LAT-1:0] r_pv;
  logic [AW-1:0]       r_pa [W_PIPE_LAT];

  logic [CW-1:0]       w_max, w_n;
  logic                w_done, w_accept, w_issue;

  assign w_max    = CW'(REG_WORDS) << lmul_i;
  assign w_n      = (words_i < w_max) ? words_i : w_max;
  // r_ren still counts as in flight: it feeds the write pipe on the next edge.
  assign w_done   = (r_state == S_DRAIN) && !r_ren && !(|r_pv);
  assign w_issue  = (r_state == S_READ);
  assign w_accept = start_i && ready_o;

  assign ready_o  = (r_state == S_IDLE) || w_done;
  assign done_o   = w_done;
  assign ren_o    = r_ren;
  assign raddr0_o = r_raddr0;
  assign raddr1_o = r_raddr1;
  assign wen_o    = r_pv[W_PIPE_LAT-1];
  assign waddr_o  = r_pa[W_PIPE_LAT-1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = (w_n != '0) ? S_READ : S_DRAIN;
      end
      S_READ: begin
        if (r_cnt == CW'(1)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_done) begin
          if (w_accept) w_state_nxt = (w_n != '0) ? S_READ : S_DRAIN;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_base0  <= '0;
      r_base1  <= '0;
      r_basew  <= '0;
      r_cnt    <= '0;
      r_ridx   <= '0;
      r_woff   <= '0;
      r_ren    <= 1'b0;
      r_raddr0 <= '0;
      r_raddr1 <= '0;
      r_wa     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ren   <= w_issue;
      if (w_accept) begin
        r_base0 <= raddr0_base_i;
        r_base1 <= raddr1_base_i;
        r_basew <= waddr_base_i;
        r_cnt   <= w_n;
        r_ridx  <= '0;
        r_woff  <= '0;
      end else if (w_issue) begin
        r_raddr0 <= r_base0[int'(r_ridx)*AW +: AW] + AW'(r_woff);
        r_raddr1 <= r_base1[int'(r_ridx)*AW +: AW] + AW'(r_woff);
        r_wa     <= r_basew[int'(r_ridx)*AW +: AW] + AW'(r_woff);
        r_cnt    <= r_cnt - CW'(1);
        if (r_woff == WOFF_W'(REG_WORDS - 1)) begin
          r_woff <= '0;
          r_ridx <= r_ridx + 3'd1;
        end else begin
          r_woff <= r_woff + WOFF_W'(1);
        end
      end
    end
  end

  // Write pipe is fed from the registered read stage so the first write lands
  // exactly W_PIPE_LAT cycles after the first visible read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv <= '0;
      for (int i = 0; i < W_PIPE_LAT; i++) r_pa[i] <= '0;
    end else begin
      r_pv[0] <= r_ren;
      r_pa[0] <= r_wa;
      for (int i = 1; i < W_PIPE_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vrf_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vrf_addr_sequencer
// Description : Directed self-checking bench for vrf_addr_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vrf_addr_sequencer;

  localparam int AW = 9;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic            ready_o;
  logic [1:0]      lmul_i;
  logic [CW-1:0]   words_i;
  logic [8*AW-1:0] raddr0_base_i, raddr1_base_i, waddr_base_i;
  logic            ren_o, wen_o, done_o;
  logic [AW-1:0]   raddr0_o, raddr1_o, waddr_o;

  int n_checks = 0;
  int n_errors = 0;

  int q_r0[$], q_r1[$], q_w[$];
  int first_ren, last_ren, first_wen, last_wen, done_cnt, done_k, ready_at_done;

  always #5 clk = ~clk;

  vrf_addr_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .ready_o       (ready_o),
    .lmul_i        (lmul_i),
    .words_i       (words_i),
    .raddr0_base_i (raddr0_base_i),
    .raddr1_base_i (raddr1_base_i),
    .waddr_base_i  (waddr_base_i),
    .ren_o         (ren_o),
    .raddr0_o      (raddr0_o),
    .raddr1_o      (raddr1_o),
    .wen_o         (wen_o),
    .waddr_o       (waddr_o),
    .done_o        (done_o)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8*AW-1:0] pack_lin(input int start, input int step);
    logic [8*AW-1:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[k*AW +: AW] = AW'((start + k*step) % 512);
    return v;
  endfunction

  task automatic launch(input logic [1:0] lmul, input int words,
                        input logic [8*AW-1:0] b0, input logic [8*AW-1:0] b1,
                        input logic [8*AW-1:0] bw);
    @(negedge clk);
    check("ready_before_start", int'(ready_o), 1);
    lmul_i        = lmul;
    words_i       = CW'(words);
    raddr0_base_i = b0;
    raddr1_base_i = b1;
    waddr_base_i  = bw;
    start_i       = 1'b1;
  endtask

  // Samples each negedge after the accept edge (k=1 is the first one).
  task automatic capture(input int maxc, input int poke_k);
    q_r0.delete(); q_r1.delete(); q_w.delete();
    first_ren = -1; last_ren = -1; first_wen = -1; last_wen = -1;
    done_cnt = 0; done_k = -1; ready_at_done = 0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (ren_o) begin
        q_r0.push_back(int'(raddr0_o));
        q_r1.push_back(int'(raddr1_o));
        if (first_ren < 0) first_ren = k;
        last_ren = k;
      end
      if (wen_o) begin
        q_w.push_back(int'(waddr_o));
        if (first_wen < 0) first_wen = k;
        last_wen = k;
      end
      if (done_o) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          ready_at_done = int'(ready_o);
        end
      end
      if (k == 1) start_i = 1'b0;
      if (poke_k > 0 && k == poke_k) begin
        start_i = 1'b1;
        words_i = CW'(7);
      end
      if (poke_k > 0 && k == poke_k + 2) start_i = 1'b0;
      if (done_k > 0 && k >= done_k + 4) break;
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; start_i = 1'b0; lmul_i = '0; words_i = '0;
    raddr0_base_i = '0; raddr1_base_i = '0; waddr_base_i = '0;
    #1;
    check("rst_ready", int'(ready_o), 1);
    check("rst_ren", int'(ren_o), 0);
    check("rst_wen", int'(wen_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_raddr0", int'(raddr0_o), 0);
    check("rst_waddr", int'(waddr_o), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // A: lmul=1 reg, 16 words
    launch(2'd0, 16, pack_lin(0, 300), pack_lin(32, 300), pack_lin(64, 300));
    capture(60, 0);
    check("a_ren_cnt", q_r0.size(), 16);
    check("a_wen_cnt", q_w.size(), 16);
    for (int i = 0; i < q_r0.size(); i++) begin
      check("a_raddr0", q_r0[i], i);
      check("a_raddr1", q_r1[i], 32 + i);
    end
    for (int i = 0; i < q_w.size(); i++) check("a_waddr", q_w[i], 64 + i);
    check("a_first_ren", first_ren, 2);
    check("a_wen_lat", first_wen - first_ren, 4);
    check("a_wen_nogap", last_wen - first_wen + 1, 16);
    check("a_done_cnt", done_cnt, 1);
    check("a_done_k", done_k, last_wen + 1);
    check("a_ready_at_done", ready_at_done, 1);

    // B: lmul=4 regs, 64 words crossing register boundaries
    launch(2'd2, 64, pack_lin(64, 16), pack_lin(256, 16), pack_lin(0, 16));
    capture(120, 0);
    check("b_ren_cnt", q_r0.size(), 64);
    check("b_ren_nogap", last_ren - first_ren + 1, 64);
    for (int i = 0; i < q_r0.size(); i++) begin
      check("b_raddr0", q_r0[i], 64 + i);
      check("b_raddr1", q_r1[i], 256 + i);
    end
    for (int i = 0; i < q_w.size(); i++) check("b_waddr", q_w[i], i);
    check("b_wen_cnt", q_w.size(), 64);
    check("b_done_cnt", done_cnt, 1);

    // C: words beyond the group size are clamped; slot 1 must never be used
    launch(2'd0, 40, pack_lin(100, 200), pack_lin(200, 200), pack_lin(300, 100));
    capture(80, 0);
    check("c_ren_cnt", q_r0.size(), 16);
    check("c_wen_cnt", q_w.size(), 16);
    if (q_r0.size() == 16) check("c_raddr0_last", q_r0[15], 115);
    if (q_w.size() == 16) check("c_waddr_last", q_w[15], 315);
    check("c_done_cnt", done_cnt, 1);

    // D: zero words
    launch(2'd1, 0, pack_lin(0, 16), pack_lin(0, 16), pack_lin(0, 16));
    capture(20, 0);
    check("d_ren_cnt", q_r0.size(), 0);
    check("d_wen_cnt", q_w.size(), 0);
    check("d_done_k", done_k, 1);
    check("d_done_cnt", done_cnt, 1);

    // E: address wrap; a start pulse during READ must be ignored
    launch(2'd0, 4, pack_lin(510, 16), pack_lin(5, 16), pack_lin(509, 16));
    capture(40, 3);
    check("e_ren_cnt", q_r0.size(), 4);
    if (q_r0.size() == 4) begin
      check("e_raddr0_0", q_r0[0], 510);
      check("e_raddr0_1", q_r0[1], 511);
      check("e_raddr0_2", q_r0[2], 0);
      check("e_raddr0_3", q_r0[3], 1);
    end
    if (q_w.size() == 4) check("e_waddr_3", q_w[3], 0);
    check("e_wen_cnt", q_w.size(), 4);
    check("e_done_cnt", done_cnt, 1);
    check("e_idle_after", int'(ready_o), 1);

    // F: asynchronous reset mid-READ at the 5th read strobe
    launch(2'd1, 32, pack_lin(0, 16), pack_lin(128, 16), pack_lin(256, 16));
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
      if (ren_o) cnt++;
      if (cnt == 5) break;
    end
    check("f_reached_5th_ren", cnt, 5);
    #2 rst = 1'b1;
    #1;
    check("f_rst_ren", int'(ren_o), 0);
    check("f_rst_wen", int'(wen_o), 0);
    check("f_rst_done", int'(done_o), 0);
    check("f_rst_raddr0", int'(raddr0_o), 0);
    check("f_rst_raddr1", int'(raddr1_o), 0);
    check("f_rst_waddr", int'(waddr_o), 0);
    check("f_rst_ready", int'(ready_o), 1);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ren_o || wen_o || done_o) cnt++;
    end
    check("f_quiet_after_rst", cnt, 0);
    check("f_ready_after_rst", int'(ready_o), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
